// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO on an inferred dual-port RAM with a registered read port
// Optional sticky overflow/underflow outputs: define FIFO_SYNC_ERR_FLAGS_EN.
module fifo_sync #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int ALMOST_FULL_LVL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come only from registered pointers, so they lag the accepting edge by one cycle.
    assign empty       = (wptr == rptr);
    assign full        = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                         (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
    assign count       = wptr - rptr;
    assign almost_full = (count >= AF_LVL);

    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    // RAM has no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_ok;
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                r_data <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr   <= rptr + 1'b1;
            end
        end
    end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow <= 1'b1;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
